// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns mnemonic-level requests into 32-bit words
// and streams them into instruction memory through a stalling write port.
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [31:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err_illegal,
  output logic              err_overflow,
  input  logic              err_clr
);
  typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         word2_q, word2_d;
  logic                two_q, two_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ill_q, ill_d;
  logic                ovf_q, ovf_d;

  logic [31:0] enc_w1, enc_w2;
  logic        enc_two, enc_legal;
  logic [4:0]  rs_f, rt_f, rd_f, sa_f;
  logic [5:0]  func, opc;

  // Field encoder: purely combinational on the request inputs.
  always_comb begin
    enc_w1    = '0;
    enc_w2    = '0;
    enc_two   = 1'b0;
    enc_legal = 1'b1;
    rs_f      = in_rs;
    rt_f      = in_rt;
    rd_f      = in_rd;
    sa_f      = in_sa;
    func      = '0;
    opc       = '0;
    case (in_op)
      6'd0:  func = 6'b100000;
      6'd1:  func = 6'b100001;
      6'd2:  func = 6'b100010;
      6'd3:  func = 6'b100011;
      6'd4:  func = 6'b100100;
      6'd5:  func = 6'b100101;
      6'd6:  func = 6'b100110;
      6'd7:  func = 6'b100111;
      6'd8:  func = 6'b101010;
      6'd9:  func = 6'b101011;
      6'd10: func = 6'b000000;
      6'd11: func = 6'b000010;
      6'd12: func = 6'b000011;
      6'd13: func = 6'b000100;
      6'd14: func = 6'b000110;
      6'd15: func = 6'b000111;
      6'd16: func = 6'b001000;
      6'd17: func = 6'b001001;
      6'd18: opc  = 6'b100011;
      6'd19: opc  = 6'b101011;
      6'd20: opc  = 6'b001000;
      6'd21: opc  = 6'b001001;
      6'd22: opc  = 6'b001100;
      6'd23: opc  = 6'b001101;
      6'd24: opc  = 6'b001110;
      6'd25: opc  = 6'b001111;
      6'd26: opc  = 6'b000001;
      6'd27: opc  = 6'b000001;
      6'd28: opc  = 6'b000100;
      6'd29: opc  = 6'b000101;
      6'd30: opc  = 6'b000110;
      6'd31: opc  = 6'b000111;
      6'd32: opc  = 6'b000010;
      6'd33: opc  = 6'b000011;
      default: ;
    endcase

    if (in_op <= 6'd17) begin
      if (in_op inside {6'd10, 6'd11, 6'd12}) rs_f = '0;
      else                                    sa_f = '0;
      if (in_op == 6'd16) begin
        rt_f = '0;
        rd_f = '0;
      end
      if (in_op == 6'd17) rt_f = '0;
      enc_w1 = {6'b000000, rs_f, rt_f, rd_f, sa_f, func};
    end else if (in_op <= 6'd31) begin
      if (in_op == 6'd25) rs_f = '0;
      if (in_op inside {6'd26, 6'd30, 6'd31}) rt_f = 5'd0;
      if (in_op == 6'd27) rt_f = 5'd1;
      enc_w1 = {opc, rs_f, rt_f, in_imm[15:0]};
    end else if (in_op <= 6'd33) begin
      enc_w1 = {opc, in_target};
    end else if (in_op == 6'd34) begin
      enc_w1 = 32'h0;
    end else if (in_op == 6'd35) begin
      // LI: zero low half (including v==0) needs only the LUI
      if (in_imm[15:0] == 16'h0) begin
        enc_w1 = {6'b001111, 5'd0, in_rt, in_imm[31:16]};
      end else if (in_imm[31:16] == 16'h0) begin
        enc_w1 = {6'b001101, 5'd0, in_rt, in_imm[15:0]};
      end else begin
        enc_w1  = {6'b001111, 5'd0, in_rt, in_imm[31:16]};
        enc_w2  = {6'b001101, in_rt, in_rt, in_imm[15:0]};
        enc_two = 1'b1;
      end
    end else begin
      enc_legal = 1'b0;
    end
  end

  assign full         = (count_q == DEPTH);
  assign in_ready     = (state_q == IDLE);
  assign imem_we      = (state_q != IDLE) && !full;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign word_count   = count_q;
  assign err_illegal  = ill_q;
  assign err_overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    word2_d = word2_q;
    two_d   = two_q;
    addr_d  = addr_q;
    count_d = count_q;
    ill_d   = err_clr ? 1'b0 : ill_q;
    ovf_d   = err_clr ? 1'b0 : ovf_q;
    case (state_q)
      IDLE: begin
        if (addr_load) begin
          addr_d  = addr_base;
          count_d = '0;
        end
        if (in_valid) begin
          if (enc_legal) begin
            wdata_d = enc_w1;
            word2_d = enc_w2;
            two_d   = enc_two;
            state_d = EMIT;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      EMIT, EMIT2: begin
        // A full memory drops the word without waiting for the port.
        if (full || imem_ready) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
          end
          if (state_q == EMIT && two_q) begin
            state_d = EMIT2;
            wdata_d = word2_q;
            two_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wdata_q <= '0;
      word2_q <= '0;
      two_q   <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      word2_q <= word2_d;
      two_q   <= two_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based reference model checked every cycle,
// directed literal cases, then randomized traffic with a small memory.
module tb_instr_encoder;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    in_op = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
  logic [31:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          addr_load = 1'b0;
  logic [AW-1:0] addr_base = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ready = 1'b1;
  logic [AW:0]   word_count;
  logic          full;
  logic          err_illegal;
  logic          err_overflow;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target), .addr_load(addr_load),
    .addr_base(addr_base), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ready(imem_ready), .word_count(word_count),
    .full(full), .err_illegal(err_illegal), .err_overflow(err_overflow),
    .err_clr(err_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [5:0] RF  [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                      6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02,
                                      6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09};
  localparam logic [5:0] IOP [16] = '{6'h23, 6'h2B, 6'h08, 6'h09, 6'h0C, 6'h0D,
                                      6'h0E, 6'h0F, 6'h01, 6'h01, 6'h04, 6'h05,
                                      6'h06, 6'h07, 6'h02, 6'h03};

  // Returns how many words the request expands into; 0 means illegal.
  function automatic int encode(input int o, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sa,
                                input logic [31:0] imm, input logic [25:0] tg,
                                output logic [31:0] w0, output logic [31:0] w1);
    logic [15:0] hi, lo;
    hi = imm[31:16];
    lo = imm[15:0];
    w0 = '0;
    w1 = '0;
    if (o < 18) begin
      if (o >= 10 && o <= 12) rs = 0; else sa = 0;
      if (o == 16) begin rt = 0; rd = 0; end
      if (o == 17) rt = 0;
      w0 = {6'd0, rs, rt, rd, sa, RF[o]};
      return 1;
    end
    if (o < 32) begin
      if (o == 25) rs = 0;
      if (o == 26 || o == 30 || o == 31) rt = 0;
      if (o == 27) rt = 1;
      w0 = {IOP[o-18], rs, rt, lo};
      return 1;
    end
    if (o < 34) begin
      w0 = {IOP[o-18], tg};
      return 1;
    end
    if (o == 34) return 1;
    if (o == 35) begin
      if (lo == 0) begin w0 = {6'h0F, 5'd0, rt, hi}; return 1; end
      if (hi == 0) begin w0 = {6'h0D, 5'd0, rt, lo}; return 1; end
      w0 = {6'h0F, 5'd0, rt, hi};
      w1 = {6'h0D, rt, rt, lo};
      return 2;
    end
    return 0;
  endfunction

  logic [31:0] pq [$];
  int          m_addr = 0, m_cnt = 0;
  bit          m_ill = 0, m_ovf = 0;
  bit          log_en = 1;
  logic [63:0] wr_log [$];

  task automatic model_step();
    bit si, so;
    int n;
    logic [31:0] w0, w1;
    si = 0;
    so = 0;
    if (!rst_n) begin
      pq.delete();
      m_addr = 0; m_cnt = 0; m_ill = 0; m_ovf = 0;
      return;
    end
    if (log_en && imem_we && imem_ready) wr_log.push_back({32'(imem_addr), imem_wdata});
    if (pq.size() > 0) begin
      if (m_cnt == DEPTH) begin
        void'(pq.pop_front());
        so = 1;
      end else if (imem_ready) begin
        void'(pq.pop_front());
        m_addr = (m_addr + 1) % DEPTH;
        m_cnt++;
      end
    end else begin
      if (addr_load) begin m_addr = int'(addr_base); m_cnt = 0; end
      if (in_valid) begin
        n = encode(int'(in_op), in_rs, in_rt, in_rd, in_sa, in_imm, in_target, w0, w1);
        if (n == 0) si = 1;
        else begin
          pq.push_back(w0);
          if (n == 2) pq.push_back(w1);
        end
      end
    end
    if (err_clr) begin m_ill = 0; m_ovf = 0; end
    if (si) m_ill = 1;
    if (so) m_ovf = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(pq.size() == 0));
    chk("imem_we", 64'(imem_we), 64'(pq.size() > 0 && m_cnt != DEPTH));
    if (pq.size() > 0 && m_cnt != DEPTH) chk("imem_wdata", 64'(imem_wdata), 64'(pq[0]));
    chk("imem_addr", 64'(imem_addr), 64'(m_addr));
    chk("word_count", 64'(word_count), 64'(m_cnt));
    chk("full", 64'(full), 64'(m_cnt == DEPTH));
    chk("err_illegal", 64'(err_illegal), 64'(m_ill));
    chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL %s: in_ready still %b after %0d cycles, expected 1", nm, in_ready, t);
    end
  endtask

  task automatic send(input int op, input int rs, input int rt, input int rd, input int sa,
                      input logic [31:0] imm, input logic [25:0] tg);
    wait_idle("send_wait");
    in_valid = 1'b1;
    in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_sa = 5'(sa);
    in_imm = imm; in_target = tg;
    step();
    in_valid = 1'b0;
  endtask

  task automatic load(input int base);
    wait_idle("load_wait");
    addr_load = 1'b1;
    addr_base = AW'(base);
    step();
    addr_load = 1'b0;
  endtask

  task automatic expect_wr(input string nm, input int a, input logic [31:0] w);
    logic [63:0] e;
    if (wr_log.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no write seen, expected %h at addr %0d", nm, w, a);
    end else begin
      e = wr_log.pop_front();
      chk(nm, e, {32'(a), w});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a0, a1;
    int n;

    n = encode(0, 1, 2, 3, 0, 0, 0, a0, a1);
    chk("model_add", {32'(n), a0}, {32'd1, 32'h00221820});
    n = encode(10, 7, 2, 3, 4, 0, 0, a0, a1);
    chk("model_sll", {32'(n), a0}, {32'd1, 32'h00021900});
    n = encode(35, 0, 8, 0, 0, 32'h12345678, 0, a0, a1);
    chk("model_li", {a0, a1}, {32'h3C081234, 32'h35085678});

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_wdata", 64'(imem_wdata), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_count", 64'(word_count), 64'h0);
    step();

    send(0, 1, 2, 3, 0, 0, 0);
    chk("add_lat_we", 64'(imem_we), 64'h1);
    chk("add_lat_wd", 64'(imem_wdata), 64'h00221820);
    step();
    chk("add_cnt", 64'(word_count), 64'd1);
    expect_wr("add_wr", 0, 32'h00221820);

    send(35, 0, 8, 0, 0, 32'h12345678, 0);
    chk("li_busy1", 64'(in_ready), 64'h0);
    step();
    chk("li_busy2", 64'(in_ready), 64'h0);
    step();
    chk("li_done", 64'(in_ready), 64'h1);
    expect_wr("li_hi", 1, 32'h3C081234);
    expect_wr("li_lo", 2, 32'h35085678);

    load(0);
    send(35, 0, 8, 0, 0, 32'h0000BEEF, 0);
    send(35, 0, 8, 0, 0, 32'hABCD0000, 0);
    send(27, 4, 9, 0, 0, 32'h0000FFFE, 0);
    send(33, 0, 0, 0, 0, 0, 26'h0000100);
    step();
    chk("full_after4", 64'(full), 64'h1);
    expect_wr("li_orionly", 0, 32'h3408BEEF);
    expect_wr("li_luionly", 1, 32'h3C08ABCD);
    expect_wr("bgez", 2, 32'h0481FFFE);
    expect_wr("jal", 3, 32'h0C000100);

    load(0);
    send(10, 7, 2, 3, 4, 0, 0);
    send(35, 0, 8, 0, 0, 32'h0, 0);
    step();
    expect_wr("sll", 0, 32'h00021900);
    expect_wr("li_zero", 1, 32'h3C080000);

    imem_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 0);
    repeat (3) begin
      chk("stall_we", 64'(imem_we), 64'h1);
      chk("stall_cnt", 64'(word_count), 64'd2);
      step();
    end
    imem_ready = 1'b1;
    step();
    chk("stall_cnt_after", 64'(word_count), 64'd3);
    expect_wr("stall_wr", 2, 32'h00221820);

    send(40, 0, 0, 0, 0, 0, 0);
    chk("ill_flag", 64'(err_illegal), 64'h1);
    chk("ill_nowr", 64'(imem_we), 64'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ill_clr", 64'(err_illegal), 64'h0);

    load(0);
    repeat (5) send(34, 0, 0, 0, 0, 0, 0);
    step();
    chk("ovf_full", 64'(full), 64'h1);
    chk("ovf_flag", 64'(err_overflow), 64'h1);
    chk("ovf_addr", 64'(imem_addr), 64'h0);
    chk("ovf_cnt", 64'(word_count), 64'd4);
    for (int i = 0; i < 4; i++) expect_wr("nop_wr", i, 32'h0);
    chk("ovf_extra", 64'(wr_log.size()), 64'd0);
    load(2);
    chk("load_cnt", 64'(word_count), 64'd0);
    chk("load_full", 64'(full), 64'h0);
    addr_load = 1'b1;
    addr_base = AW'(1);
    send(34, 0, 0, 0, 0, 0, 0);
    addr_load = 1'b0;
    step();
    expect_wr("load_accept", 1, 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    imem_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 0);
    chk("rst_mid_we_pre", 64'(imem_we), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 64'(imem_we), 64'h0);
    chk("rst_mid_cnt", 64'(word_count), 64'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    imem_ready = 1'b1;
    step();
    chk("rst_mid_ready", 64'(in_ready), 64'h1);
    wr_log.delete();

    log_en = 0;
    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode = $urandom_range(0, 3);
      in_valid   = ($urandom_range(0, 2) != 0);
      in_op      = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
      in_rs      = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom); in_sa = 5'($urandom);
      in_imm     = $urandom;
      if (mode == 1) in_imm[31:16] = '0;
      if (mode == 2) in_imm[15:0] = '0;
      if (mode == 3 && $urandom_range(0, 3) == 0) in_imm = '0;
      in_target  = 26'($urandom);
      imem_ready = ($urandom_range(0, 9) < 7);
      addr_load  = ($urandom_range(0, 9) == 0);
      addr_base  = AW'($urandom);
      err_clr    = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 1'b0; addr_load = 1'b0; err_clr = 1'b0; imem_ready = 1'b1;
    wait_idle("final_idle");
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
